// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by uart_rx, uart_baud_counter and UartTx.
// Holds FSM state encodings, frame widths, default bit time, parity helper.
package uart_pkg;

   localparam int DATA_BITS        = 8;
   localparam int CLKS_PER_BIT_DEF = 868;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_PARITY    = 3'd3,
      ST_STOP      = 3'd4,
      ST_WAIT_IDLE = 3'd5
   } uartState_t;

   // Even parity bit for a data word (XOR of all data bits).
   function automatic logic evenParity(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: bit-time counter with half-bit and full-bit ticks.
// Counts 0..CLKS_PER_BIT-1 and wraps; load clears to 0. Shared with UartTx.
module uart_baud_counter #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic enable,
   output logic halfTick,
   output logic fullTick
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

   logic [CW-1:0] count;

   // Free-running bit-time count, cleared by load, wrapping at the bit end.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= '0;
      end else if (enable) begin
         count <= (count == LAST) ? '0 : count + 1'b1;
      end
   end

   assign halfTick = (count == HALF);
   assign fullTick = (count == LAST);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling and framing-error strobe.
// Define UART_RX_PARITY_EN for 8E1 frames and the uartRxParityErr port.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rxEnable,
   input  logic                 uartRxBit,
   output logic [DATA_BITS-1:0] uartOutByte,
   output logic                 uartRxDone,
   output logic                 uartRxFrameErr
`ifdef UART_RX_PARITY_EN
   ,
   output logic                 uartRxParityErr
`endif
);

   localparam int BW = $clog2(DATA_BITS);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
   localparam uartState_t AFTER_DATA = ST_PARITY;
`else
   localparam uartState_t AFTER_DATA = ST_STOP;
`endif

   uartState_t           state;
   uartState_t           nextState;
   logic                 sync1;
   logic                 rxSync;
   logic                 cntLoad;
   logic                 cntEn;
   logic                 halfTick;
   logic                 fullTick;
   logic [BW-1:0]        bitIdx;
   logic                 lastBit;
   logic [DATA_BITS-1:0] shiftReg;
   logic                 sampleData;
   logic                 setDone;
   logic                 setFrameErr;
   logic                 acceptByte;
`ifdef UART_RX_PARITY_EN
   logic                 sampleParity;
   logic                 parityBad;
`endif

   uart_baud_counter #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) baudCnt (
      .clk     (clk),
      .reset   (reset),
      .load    (cntLoad),
      .enable  (cntEn),
      .halfTick(halfTick),
      .fullTick(fullTick)
   );

   assign lastBit = (bitIdx == LAST_BIT);

   // Two-flop synchronizer; idles high so reset looks like an idle line.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1  <= 1'b1;
         rxSync <= 1'b1;
      end else begin
         sync1  <= uartRxBit;
         rxSync <= sync1;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= nextState;
   end

   // Next-state logic; dropping rxEnable aborts any frame in progress.
   always_comb begin
      nextState = state;
      unique case (state)
         ST_IDLE:
            if (rxEnable && !rxSync) nextState = ST_START;
         ST_START:
            if (halfTick) nextState = rxSync ? ST_IDLE : ST_DATA;
         ST_DATA:
            if (fullTick && lastBit) nextState = AFTER_DATA;
         ST_PARITY:
            if (fullTick) nextState = ST_STOP;
         ST_STOP:
            if (fullTick) nextState = rxSync ? ST_IDLE : ST_WAIT_IDLE;
         ST_WAIT_IDLE:
            if (rxSync) nextState = ST_IDLE;
         default:
            nextState = ST_IDLE;
      endcase
      if (!rxEnable && state != ST_IDLE) nextState = ST_IDLE;
   end

   // Per-state controls: counter load/enable, sample and strobe requests.
   always_comb begin
      cntLoad     = 1'b0;
      cntEn       = 1'b0;
      sampleData  = 1'b0;
      setDone     = 1'b0;
      setFrameErr = 1'b0;
`ifdef UART_RX_PARITY_EN
      sampleParity = 1'b0;
`endif
      unique case (state)
         ST_IDLE, ST_WAIT_IDLE: cntLoad = 1'b1;
         ST_START: begin
            cntEn   = 1'b1;
            cntLoad = halfTick;
         end
         ST_DATA: begin
            cntEn      = 1'b1;
            sampleData = fullTick;
         end
         ST_PARITY: begin
            cntEn = 1'b1;
`ifdef UART_RX_PARITY_EN
            sampleParity = fullTick;
`endif
         end
         ST_STOP: begin
            cntEn       = 1'b1;
            setDone     = fullTick && rxSync;
            setFrameErr = fullTick && !rxSync;
         end
         default: cntLoad = 1'b1;
      endcase
      if (!rxEnable) begin
         sampleData  = 1'b0;
         setDone     = 1'b0;
         setFrameErr = 1'b0;
`ifdef UART_RX_PARITY_EN
         sampleParity = 1'b0;
`endif
      end
   end

   // Shift register, LSB first, with the data bit index.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shiftReg <= '0;
         bitIdx   <= '0;
      end else if (state == ST_IDLE) begin
         bitIdx <= '0;
      end else if (sampleData) begin
         shiftReg <= {rxSync, shiftReg[DATA_BITS-1:1]};
         bitIdx   <= bitIdx + 1'b1;
      end
   end

`ifdef UART_RX_PARITY_EN
   // Parity check at mid parity bit; a bad frame withholds its byte.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         parityBad       <= 1'b0;
         uartRxParityErr <= 1'b0;
      end else begin
         uartRxParityErr <= sampleParity &&
                            (rxSync != evenParity(shiftReg));
         if (state == ST_IDLE)
            parityBad <= 1'b0;
         else if (sampleParity)
            parityBad <= (rxSync != evenParity(shiftReg));
      end
   end

   assign acceptByte = setDone && !parityBad;
`else
   assign acceptByte = setDone;
`endif

   // Registered byte output and one-cycle result strobes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         uartOutByte    <= '0;
         uartRxDone     <= 1'b0;
         uartRxFrameErr <= 1'b0;
      end else begin
         uartRxDone     <= acceptByte;
         uartRxFrameErr <= setFrameErr;
         if (acceptByte) uartOutByte <= shiftReg;
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx (short bit time).
// Build with UART_RX_PARITY_EN defined to cover the 8E1 variant.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int C = 16;
`ifdef UART_RX_PARITY_EN
   localparam int LAT = 2 + C/2 + 10*C;
`else
   localparam int LAT = 2 + C/2 + 9*C;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       rxEnable = 1'b0;
   logic       rxBit = 1'b1;
   logic [7:0] outByte;
   logic       done;
   logic       frameErr;
   logic       parityErr;

   uart_rx #(.CLKS_PER_BIT(C)) dut (
      .clk           (clk),
      .reset         (reset),
      .rxEnable      (rxEnable),
      .uartRxBit     (rxBit),
      .uartOutByte   (outByte),
      .uartRxDone    (done),
      .uartRxFrameErr(frameErr)
`ifdef UART_RX_PARITY_EN
      ,
      .uartRxParityErr(parityErr)
`endif
   );

`ifndef UART_RX_PARITY_EN
   assign parityErr = 1'b0;
`endif

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int doneCnt = 0;
   int ferrCnt = 0;
   int perrCnt = 0;
   int multiCnt = 0;
   int lastDoneCyc = 0;
   int fallCyc = 0;
   logic [7:0] gotQ[$];

   // Strobe monitor, sampled away from the active edge.
   always @(negedge clk) begin
      if (done) begin
         doneCnt++;
         lastDoneCyc = cyc;
         gotQ.push_back(outByte);
      end
      if (frameErr) ferrCnt++;
      if (parityErr) perrCnt++;
      if (int'(done) + int'(frameErr) + int'(parityErr) > 1) multiCnt++;
   end

   int total = 0;
   int passed = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic chkNear(input string name, input int act,
                          input int exp, input int tol);
      total++;
      if (act >= exp - tol && act <= exp + tol) passed++;
      else $display("FAIL %s: got %0d, expected %0d +/- %0d",
                    name, act, exp, tol);
   endtask

   task automatic hold(input logic b, input int n);
      rxBit = b;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic goodPar(input logic [7:0] d);
      return logic'($countones(d) % 2);
   endfunction

   task automatic sendFrame(input logic [7:0] d, input logic stopBit,
                            input logic parBit);
      fallCyc = cyc;
      hold(1'b0, C);
      for (int i = 0; i < 8; i++) hold(d[i], C);
`ifdef UART_RX_PARITY_EN
      hold(parBit, C);
`endif
      hold(stopBit, C);
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stopBit;
      int         gapBits;
      int         expDone;
      int         expFerr;
      logic [7:0] expByte;
   } vec_t;

   vec_t vecs[7];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int d0, f0, p0;
      logic [7:0] expQ[$];
      logic [7:0] lastGood;
      int expFerr, expPerr;

      vecs[0] = '{8'h72, 1'b1, 1, 1, 0, 8'h72};
      vecs[1] = '{8'h00, 1'b1, 0, 1, 0, 8'h00};
      vecs[2] = '{8'hFF, 1'b1, 0, 1, 0, 8'hFF};
      vecs[3] = '{8'h55, 1'b1, 2, 1, 0, 8'h55};
      vecs[4] = '{8'hA5, 1'b0, 1, 0, 1, 8'h55};
      vecs[5] = '{8'h3C, 1'b1, 1, 1, 0, 8'h3C};
      vecs[6] = '{8'h81, 1'b1, 0, 1, 0, 8'h81};

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      chk("reset_byte", int'(outByte), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_ferr", int'(frameErr), 0);
      rxEnable = 1'b1;
      reset = 1'b1;
      hold(1'b1, 2 * C);

      // Table-driven frames, including zero-gap back-to-back runs.
      for (int i = 0; i < 7; i++) begin
         d0 = doneCnt;
         f0 = ferrCnt;
         sendFrame(vecs[i].data, vecs[i].stopBit, goodPar(vecs[i].data));
         if (i == 0) chkNear("latency", lastDoneCyc - fallCyc, LAT, 2);
         chk($sformatf("vec%0d_done", i), doneCnt - d0, vecs[i].expDone);
         chk($sformatf("vec%0d_ferr", i), ferrCnt - f0, vecs[i].expFerr);
         chk($sformatf("vec%0d_byte", i), int'(outByte),
             int'(vecs[i].expByte));
         hold(1'b1, vecs[i].gapBits * C);
      end

      // Short low glitch on an idle line.
      d0 = doneCnt;
      f0 = ferrCnt;
      hold(1'b0, 3);
      hold(1'b1, 3 * C);
      chk("glitch_done", doneCnt - d0, 0);
      chk("glitch_ferr", ferrCnt - f0, 0);
      chk("glitch_byte", int'(outByte), 8'h81);

      // Bad stop bit, then line stuck low for 20 bit times.
      d0 = doneCnt;
      f0 = ferrCnt;
      sendFrame(8'hA5, 1'b0, goodPar(8'hA5));
      hold(1'b0, 20 * C);
      chk("brk_ferr", ferrCnt - f0, 1);
      chk("brk_done", doneCnt - d0, 0);
      chk("brk_byte", int'(outByte), 8'h81);
      hold(1'b1, 2 * C);
      sendFrame(8'h3C, 1'b1, goodPar(8'h3C));
      hold(1'b1, C);
      chk("after_brk_done", doneCnt - d0, 1);
      chk("after_brk_ferr", ferrCnt - f0, 1);
      chk("after_brk_byte", int'(outByte), 8'h3C);

      // Reset mid-DATA, then rxEnable dropped mid-frame.
      d0 = doneCnt;
      f0 = ferrCnt;
      hold(1'b0, C);
      hold(1'b0, C);
      hold(1'b1, C / 2);
      reset = 1'b0;
      #1;
      chk("midrst_byte", int'(outByte), 0);
      chk("midrst_done", int'(done), 0);
      hold(1'b1, 3);
      reset = 1'b1;
      hold(1'b1, 2 * C);
      hold(1'b0, C);
      hold(1'b1, C);
      hold(1'b0, C / 2);
      rxEnable = 1'b0;
      hold(1'b0, C / 2);
      hold(1'b1, 7 * C);
      rxEnable = 1'b1;
      hold(1'b1, C);
      chk("abort_done", doneCnt - d0, 0);
      chk("abort_ferr", ferrCnt - f0, 0);
      chk("abort_byte", int'(outByte), 0);
      sendFrame(8'h72, 1'b1, goodPar(8'h72));
      hold(1'b1, C);
      chk("post_abort_done", doneCnt - d0, 1);
      chk("post_abort_byte", int'(outByte), 8'h72);

`ifdef UART_RX_PARITY_EN
      // Wrong then correct parity bit.
      d0 = doneCnt;
      p0 = perrCnt;
      sendFrame(8'h72, 1'b1, ~goodPar(8'h72));
      hold(1'b1, C);
      chk("badpar_perr", perrCnt - p0, 1);
      chk("badpar_done", doneCnt - d0, 0);
      chk("badpar_byte", int'(outByte), 8'h72);
      sendFrame(8'h72, 1'b1, goodPar(8'h72));
      hold(1'b1, C);
      chk("goodpar_perr", perrCnt - p0, 1);
      chk("goodpar_done", doneCnt - d0, 1);
      chk("goodpar_byte", int'(outByte), 8'h72);
`endif

      // Random frames against a frame-level reference model.
      gotQ.delete();
      lastGood = 8'h72;
      expFerr = 0;
      expPerr = 0;
      f0 = ferrCnt;
      p0 = perrCnt;
      for (int n = 0; n < 12; n++) begin
         logic [7:0] d;
         logic stopBit, wrong, bad;
         int gap;
         d = 8'($urandom);
         stopBit = ($urandom % 4) != 0;
         wrong = ($urandom % 4) == 0;
`ifdef UART_RX_PARITY_EN
         bad = wrong;
`else
         bad = 1'b0;
`endif
         gap = stopBit ? int'($urandom % 3) : 1 + int'($urandom % 2);
         if (bad) expPerr++;
         if (!stopBit) expFerr++;
         else if (!bad) begin
            expQ.push_back(d);
            lastGood = d;
         end
         sendFrame(d, stopBit, goodPar(d) ^ wrong);
         hold(1'b1, gap * C);
      end
      hold(1'b1, C);
      chk("rand_count", gotQ.size(), expQ.size());
      for (int k = 0; k < expQ.size(); k++) begin
         if (k < gotQ.size())
            chk($sformatf("rand_byte%0d", k), int'(gotQ[k]), int'(expQ[k]));
      end
      chk("rand_ferr", ferrCnt - f0, expFerr);
      chk("rand_perr", perrCnt - p0, expPerr);
      chk("rand_last_byte", int'(outByte), int'(lastGood));
      chk("strobes_exclusive", multiCnt, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
